// File: rtl/dcm_lock_ctrl_pkg.sv
// State encodings, saturation constant and elaboration helpers shared by the
// DCM lock controller.
package dcm_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [7:0] LOSS_CNT_SAT = 8'd255;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for a single asynchronous status bit, with a
// synchronous active-high reset that clears both stages.
module lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/dcm_lock_ctrl.sv
// Sequences the DCM_SP reset, waits for stable lock before releasing the
// system reset, retries on timeout or lock loss, and latches a terminal failure.
module dcm_lock_ctrl
    import dcm_lock_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       CLKIN_IN,
    input  logic       RST_IN,
    input  logic       LOCKED_IN,
    output logic       DCM_RST_OUT,
    output logic       SYS_RST_OUT,
    output logic       READY_OUT,
    output logic       FAIL_OUT,
    output logic [3:0] RETRY_CNT_OUT,
    output logic [7:0] LOSS_CNT_OUT
);

    localparam int TIMER_W = $clog2(maxOf3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [TIMER_W-1:0] RST_TERM    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_TERM   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_TERM = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRY);

    state_t               r_state;
    state_t               w_next;
    logic                 w_failure;
    logic                 w_lk_s;
    logic [TIMER_W-1:0]   r_timer;
    logic [3:0]           r_retry;
    logic [7:0]           r_loss;

    lock_sync u_lock_sync (
        .i_clk   (CLKIN_IN),
        .i_rst   (RST_IN),
        .i_async (LOCKED_IN),
        .o_sync  (w_lk_s)
    );

    always_ff @(posedge CLKIN_IN) begin
        if (RST_IN) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Lock beats timeout in WAIT_LOCK; loss beats terminal count in STABLE.
    always_comb begin
        w_next    = r_state;
        w_failure = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (r_timer == RST_TERM) begin
                    w_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_next = ST_STABLE;
                end else if (r_timer == LOCK_TERM) begin
                    w_failure = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_lk_s) begin
                    w_failure = 1'b1;
                end else if (r_timer == STABLE_TERM) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_lk_s) begin
                    w_next = ST_RESET;
                end
            end
            ST_FAIL: begin
                w_next = ST_FAIL;
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase
        if (w_failure) begin
            w_next = (r_retry == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
        end
    end

    always_comb begin
        DCM_RST_OUT = 1'b0;
        SYS_RST_OUT = 1'b1;
        READY_OUT   = 1'b0;
        FAIL_OUT    = 1'b0;
        case (r_state)
            ST_RESET: begin
                DCM_RST_OUT = 1'b1;
            end
            ST_RUN: begin
                SYS_RST_OUT = 1'b0;
                READY_OUT   = 1'b1;
            end
            ST_FAIL: begin
                DCM_RST_OUT = 1'b1;
                FAIL_OUT    = 1'b1;
            end
            default: begin
                DCM_RST_OUT = 1'b0;
            end
        endcase
    end

    // Timer is held at zero in RUN and FAIL, so it can only count toward a terminal value.
    always_ff @(posedge CLKIN_IN) begin
        if (RST_IN) begin
            r_timer <= '0;
            r_retry <= 4'd0;
            r_loss  <= 8'd0;
        end else begin
            if ((w_next != r_state) || (r_state == ST_RUN) || (r_state == ST_FAIL)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if ((r_state == ST_STABLE) && (w_next == ST_RUN)) begin
                r_retry <= 4'd0;
            end else if (w_failure && (w_next == ST_RESET)) begin
                r_retry <= r_retry + 4'd1;
            end

            if ((r_state == ST_RUN) && (w_next == ST_RESET) && (r_loss != LOSS_CNT_SAT)) begin
                r_loss <= r_loss + 8'd1;
            end
        end
    end

    assign RETRY_CNT_OUT = r_retry;
    assign LOSS_CNT_OUT  = r_loss;

endmodule
